// File: rtl/yacc_lru_cache_if.sv
// Request/response and fill-memory bus of the compressed LRU cache.
// The slave modport is the cache's view; the master modport is the
// requester/memory side.
interface yacc_lru_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/yacc_lru_cache.sv
// Set-associative cache with compression-class way partitioning
// (CF1 / CF2 / CF4), superblock tags and a full per-set LRU order.
module yacc_lru_cache #(
  parameter int SETS   = 8,
  parameter int WAYS   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512
) (
  input  logic        clock,
  input  logic        rst_n,
  yacc_lru_cache_if.slave bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 8 + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int RANK_W  = $clog2(WAYS);
  localparam int Q_W     = DATA_W / 4;
  localparam int unsigned CF1_END = WAYS / 2;
  localparam int unsigned CF2_END = (WAYS * 3) / 4;
  localparam int unsigned NWAYS   = WAYS;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP} state_t;
  typedef enum logic [1:0] {CLS_CF1, CLS_CF2, CLS_CF4} cls_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] fill_q;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        blk;
  logic [TAG_W-1:0]  tag;

  // per way: tag, 4 slot valids, 4 slot blockIds, recency rank, 4 data quarters
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [3:0]        vld_mem  [SETS][WAYS];
  logic [1:0]        bid_mem  [SETS][WAYS][4];
  logic [RANK_W-1:0] rank_mem [SETS][WAYS];
  logic [Q_W-1:0]    data_mem [SETS][WAYS][4];

  logic              hit;
  logic [RANK_W-1:0] hit_way;
  logic [1:0]        hit_slot;
  cls_t              hit_cls;
  logic [DATA_W-1:0] hit_data;

  cls_t              fill_cls;
  int unsigned       reg_lo, reg_hi;
  logic              found;
  logic              fill_merge;
  logic [RANK_W-1:0] fill_way;
  logic [1:0]        fill_slot;
  logic [1:0]        new_slot;
  logic [RANK_W-1:0] best_rank;

  logic              touch_en;
  logic [RANK_W-1:0] touch_way;

  assign idx = addr_q[TAG_LSB-1:8];
  assign blk = addr_q[7:6];
  assign tag = addr_q[ADDR_W-1:TAG_LSB];

  // Lookup: first matching way in index order wins
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_slot = '0;
    hit_cls  = CLS_CF1;
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!hit && tag_mem[idx][w] == tag) begin
        if (w < CF1_END) begin
          if (vld_mem[idx][w][0] && bid_mem[idx][w][0] == blk) begin
            hit = 1'b1; hit_way = RANK_W'(w); hit_slot = 2'd0; hit_cls = CLS_CF1;
          end
        end else if (w < CF2_END) begin
          if (vld_mem[idx][w][0] && bid_mem[idx][w][0] == blk) begin
            hit = 1'b1; hit_way = RANK_W'(w); hit_slot = 2'd0; hit_cls = CLS_CF2;
          end else if (vld_mem[idx][w][1] && bid_mem[idx][w][1] == blk) begin
            hit = 1'b1; hit_way = RANK_W'(w); hit_slot = 2'd1; hit_cls = CLS_CF2;
          end
        end else if (vld_mem[idx][w][blk]) begin
          hit = 1'b1; hit_way = RANK_W'(w); hit_slot = blk; hit_cls = CLS_CF4;
        end
      end
    end
  end

  // Read the hit slice and zero-extend it to a full block
  always_comb begin
    hit_data = '0;
    case (hit_cls)
      CLS_CF1: hit_data = {data_mem[idx][hit_way][3], data_mem[idx][hit_way][2],
                           data_mem[idx][hit_way][1], data_mem[idx][hit_way][0]};
      CLS_CF2: hit_data[2*Q_W-1:0] = {data_mem[idx][hit_way][{hit_slot[0], 1'b1}],
                                      data_mem[idx][hit_way][{hit_slot[0], 1'b0}]};
      default: hit_data[Q_W-1:0] = data_mem[idx][hit_way][hit_slot];
    endcase
  end

  // Compression class of the captured fill block and its way region
  always_comb begin
    fill_cls = CLS_CF1;
    reg_lo   = 0;
    reg_hi   = CF1_END;
    if (fill_q[DATA_W-1:Q_W] == '0) begin
      fill_cls = CLS_CF4; reg_lo = CF2_END; reg_hi = NWAYS;
    end else if (fill_q[DATA_W-1:2*Q_W] == '0) begin
      fill_cls = CLS_CF2; reg_lo = CF1_END; reg_hi = CF2_END;
    end
  end

  // Fill victim: merge into same-tag way, else invalid way, else region LRU
  always_comb begin
    found      = 1'b0;
    fill_merge = 1'b0;
    fill_way   = '0;
    fill_slot  = '0;
    best_rank  = '0;
    new_slot   = (fill_cls == CLS_CF4) ? blk : 2'd0;
    if (fill_cls != CLS_CF1) begin
      for (int unsigned w = 0; w < NWAYS; w++) begin
        if (!found && w >= reg_lo && w < reg_hi && tag_mem[idx][w] == tag &&
            vld_mem[idx][w] != 4'b0000) begin
          if (fill_cls == CLS_CF4 && !vld_mem[idx][w][blk]) begin
            found = 1'b1; fill_merge = 1'b1; fill_way = RANK_W'(w); fill_slot = blk;
          end else if (fill_cls == CLS_CF2 && vld_mem[idx][w][1:0] != 2'b11) begin
            found = 1'b1; fill_merge = 1'b1; fill_way = RANK_W'(w);
            fill_slot = vld_mem[idx][w][0] ? 2'd1 : 2'd0;
          end
        end
      end
    end
    for (int unsigned w = 0; w < NWAYS; w++) begin
      if (!found && w >= reg_lo && w < reg_hi && vld_mem[idx][w] == 4'b0000) begin
        found = 1'b1; fill_way = RANK_W'(w); fill_slot = new_slot;
      end
    end
    if (!found) begin
      for (int unsigned w = 0; w < NWAYS; w++) begin
        if (w >= reg_lo && w < reg_hi && (!found || rank_mem[idx][w] > best_rank)) begin
          found = 1'b1; best_rank = rank_mem[idx][w];
          fill_way = RANK_W'(w); fill_slot = new_slot;
        end
      end
    end
  end

  assign touch_en  = (state == LOOKUP && hit) || state == FILL;
  assign touch_way = (state == FILL) ? fill_way : hit_way;

  // State register
  always_ff @(posedge clock) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next        = state;
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = LOOKUP;
      end
      LOOKUP:    state_next = hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_next = MISS_WAIT;
      end
      MISS_WAIT: if (bus.mem_resp_valid) state_next = FILL;
      FILL:      state_next = RESP;
      RESP:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  assign bus.mem_req_addr = addr_q & ~(ADDR_W'(63));

  // Capture request address at acceptance and fill data in MISS_WAIT
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.req_valid) addr_q <= bus.req_addr;
    if (state == MISS_WAIT && bus.mem_resp_valid) fill_q <= bus.mem_resp_data;
  end

  // Valid bits and recency order; both reset to a known state
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < NWAYS; w++) begin
          rank_mem[s][w] <= RANK_W'(w);
          vld_mem[s][w]  <= '0;
        end
      end
    end else begin
      if (touch_en) begin
        for (int unsigned w = 0; w < NWAYS; w++) begin
          if (RANK_W'(w) == touch_way)
            rank_mem[idx][w] <= '0;
          else if (rank_mem[idx][w] < rank_mem[idx][touch_way])
            rank_mem[idx][w] <= rank_mem[idx][w] + 1'b1;
        end
      end
      if (state == FILL) begin
        if (fill_merge) vld_mem[idx][fill_way][fill_slot] <= 1'b1;
        else            vld_mem[idx][fill_way] <= 4'b0001 << fill_slot;
      end
    end
  end

  // Tag, blockId and data writes on fill (storage, no reset)
  always_ff @(posedge clock) begin
    if (state == FILL) begin
      tag_mem[idx][fill_way]            <= tag;
      bid_mem[idx][fill_way][fill_slot] <= blk;
      case (fill_cls)
        CLS_CF1: begin
          data_mem[idx][fill_way][0] <= fill_q[Q_W-1:0];
          data_mem[idx][fill_way][1] <= fill_q[2*Q_W-1:Q_W];
          data_mem[idx][fill_way][2] <= fill_q[3*Q_W-1:2*Q_W];
          data_mem[idx][fill_way][3] <= fill_q[DATA_W-1:3*Q_W];
        end
        CLS_CF2: begin
          data_mem[idx][fill_way][{fill_slot[0], 1'b0}] <= fill_q[Q_W-1:0];
          data_mem[idx][fill_way][{fill_slot[0], 1'b1}] <= fill_q[2*Q_W-1:Q_W];
        end
        default: data_mem[idx][fill_way][fill_slot] <= fill_q[Q_W-1:0];
      endcase
    end
  end

  // Response pulse: hit from LOOKUP, miss completion from FILL
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (state == LOOKUP && hit) begin
        bus.resp_valid <= 1'b1;
        bus.resp_hit   <= 1'b1;
        bus.resp_data  <= hit_data;
      end else if (state == FILL) begin
        bus.resp_valid <= 1'b1;
        bus.resp_hit   <= 1'b0;
        bus.resp_data  <= fill_q;
      end
    end
  end

  // Saturating hit/miss statistics
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == RESP && bus.resp_hit && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (state == FILL && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
endmodule

// File: doc/yacc_lru_cache.md
YACC_LRU_CACHE -- requirements
Module: yacc_lru_cache

Interface
REQ-001 Parameter SETS, default 8: number of sets; power of two, 2 to 64.
REQ-002 Parameter WAYS, default 8: ways per set; multiple of 4, 4 to 16.
REQ-003 Parameter ADDR_W, default 32: request address width.
REQ-004 Parameter DATA_W, default 512: block width in bits; multiple of 4.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset.
REQ-006 Port list (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  controller idle and able to accept a request.
- req_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  response was a hit.
- resp_data  out  DATA_W  uncompressed block.
- mem_req_valid  out  1  fill request.
- mem_req_ready  in  1  memory accepts the fill request.
- mem_req_addr  out  ADDR_W  block-aligned fill address.
- mem_resp_valid  in  1  fill data valid.
- mem_resp_data  in  DATA_W  fill block.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

Function
REQ-007 Address fields SHALL be: offset [5:0]; blockId [7:6]; index [7+log2(SETS):8]; tag = the remaining upper bits. A superblock SHALL be 4 blocks sharing one tag.
REQ-008 Ways SHALL be partitioned by compression class:
- CF1 (uncompressed): ways 0 to WAYS/2-1, one block each, with tag, blockId and valid.
- CF2: the next WAYS/4 ways, two DATA_W/2 halves each, each half with its own blockId and valid.
- CF4: the last WAYS/4 ways, four DATA_W/4 slots; slot k holds blockId k and has its own valid bit.
REQ-009 Compression class SHALL be chosen as follows:
- CF4 if the upper 3/4 of mem_resp_data is zero;
- else CF2 if the upper half is zero;
- else CF1.
- An all-zero block SHALL be CF4.
REQ-010 FSM states SHALL be IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP.
REQ-011 req_ready SHALL be 1 only in IDLE. A request is accepted on req_valid&&req_ready, and the address is registered at that edge.
REQ-012 LOOKUP SHALL compare the tag and the valid blockId slot across all ways of the set in one cycle. If several ways match, the lowest way index wins.
REQ-013 On a hit, LOOKUP->RESP. resp_valid SHALL assert exactly 2 cycles after the acceptance edge. resp_data SHALL be the stored slice, zero-extended to DATA_W.
REQ-014 On a miss, LOOKUP->MISS_REQ. mem_req_valid SHALL hold with a stable mem_req_addr (offset zeroed) until mem_req_ready; then the FSM moves to MISS_WAIT.
REQ-015 MISS_WAIT SHALL wait for mem_resp_valid, capture the data, and move to FILL. mem_resp_valid in any other state SHALL be ignored.
REQ-016 FILL SHALL select a way within the class region in this priority:
- (a) CF2/CF4 only: a way with a matching tag and the needed half/slot free;
- (b) an invalid way, lowest index first;
- (c) the LRU way of the region.
FILL->RESP with resp_hit=0 and resp_data = fill data.
REQ-017 A merge (case a) SHALL write only the free half/slot and leave the other valid data intact. An eviction SHALL clear all valid bits of the victim way before writing.
REQ-018 Per set, the block SHALL keep a full recency order over all WAYS: rank 0 = MRU, WAYS-1 = LRU. A hit or fill SHALL make the touched way MRU and shift the intervening ways down by one. The victim in (c) is the highest-ranked way in the region.
REQ-019 RESP SHALL last one cycle, then return to IDLE.
REQ-020 On a hit, hit_count SHALL increment in RESP. On a miss, miss_count SHALL increment in FILL. Both SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-021 While rst_n=0 at a clock edge:
- state SHALL become IDLE;
- all valid bits SHALL clear;
- each set's recency order SHALL become way i at rank i;
- counters SHALL be 0;
- resp_valid, resp_hit, mem_req_valid and resp_data SHALL be 0.
REQ-022 Reset in any state, including MISS_REQ or MISS_WAIT, SHALL abandon the transaction. req_ready SHALL be 1 on the first cycle after rst_n rises.

Verification (SETS=8, WAYS=8)
REQ-023 Request 0x0000_0840 after reset, fill data = 0x1234 in the low 128 bits and zero elsewhere -> mem_req_addr=0x0000_0840, resp_hit=0, data stored in way 6 slot 1, miss_count=1. Repeating the request -> resp_hit=1, resp_data=0x1234, 2-cycle latency, hit_count=1.
REQ-024 Then request 0x0000_0800 with a CF4 fill of 0xABCD -> merges into way 6 slot 0 with no eviction. Both 0x800 and 0x840 then hit.
REQ-025 Five CF1 misses to set 0 with tags 1 to 5 -> the 5th evicts way 0 (tag 1). Re-requesting tag 1 -> miss.
REQ-026 Hold mem_req_ready=0 for 3 cycles -> mem_req_valid stays 1 with a constant address, req_ready stays 0, and the FSM advances only on ready.
REQ-027 rst_n=0 during MISS_WAIT -> next cycle req_ready=1 and both counters are 0. A late mem_resp_valid writes nothing, and the prior address then misses.
